// File: rtl/ins_pkg.sv
// ins_pkg: opcodes, funct fields and oh codes shared by the RV32I encoder and decoder
package ins_pkg;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;
  localparam logic [6:0] OH_LUI   = 7'd1;
  localparam logic [6:0] OH_JAL   = 7'd3;
  localparam logic [6:0] OH_BEQ   = 7'd5;
  localparam logic [6:0] OH_BNE   = 7'd6;
  localparam logic [6:0] OH_BLT   = 7'd7;
  localparam logic [6:0] OH_ADDI  = 7'd19;
  localparam logic [6:0] OH_SLTI  = 7'd20;
  localparam logic [6:0] OH_SLTIU = 7'd21;
  localparam logic [6:0] OH_SLLI  = 7'd25;
  localparam logic [6:0] OH_SRLI  = 7'd26;
  localparam logic [6:0] OH_SRAI  = 7'd27;
  localparam logic [6:0] OH_ADD   = 7'd28;
  localparam logic [6:0] OH_SUB   = 7'd29;
  typedef enum logic [1:0] {S_IDLE, S_ENC, S_WR} state_t;
  typedef enum logic [2:0] {FMT_I, FMT_SH, FMT_R, FMT_B, FMT_U, FMT_J, FMT_NONE} fmt_t;
  function automatic fmt_t fmt_of(input logic [6:0] oh);
    case (oh)
      OH_ADDI, OH_SLTI, OH_SLTIU: return FMT_I;
      OH_SLLI, OH_SRLI, OH_SRAI:  return FMT_SH;
      OH_ADD, OH_SUB:             return FMT_R;
      OH_BEQ, OH_BNE, OH_BLT:     return FMT_B;
      OH_LUI:                     return FMT_U;
      OH_JAL:                     return FMT_J;
      default:                    return FMT_NONE;
    endcase
  endfunction
  function automatic logic in_rng(input logic signed [31:0] v, input logic signed [31:0] lo, input logic signed [31:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction
endpackage

// File: rtl/ins_pack.sv
// ins_pack: combinational RV32I field packer; INS_ENC_RANGE_CHECK_EN adds immediate range rejection
module ins_pack
  import ins_pkg::*;
(
  input  logic [6:0]  i_oh,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_bad
);
  fmt_t       w_fmt;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_range_bad;
  // pick format and funct fields from the op code, then assemble the word
  always_comb begin
    w_fmt = fmt_of(i_oh);
    w_f3  = (i_oh == OH_BNE || i_oh == OH_SLLI) ? F3_SLL :
            (i_oh == OH_SLTI)                   ? F3_SLT :
            (i_oh == OH_SLTIU)                  ? F3_SLTU :
            (i_oh == OH_BLT)                    ? F3_BLT :
            (i_oh == OH_SRLI || i_oh == OH_SRAI) ? F3_SR : F3_ADD;
    w_f7  = (i_oh == OH_SRAI || i_oh == OH_SUB) ? F7_ALT : F7_BASE;
    case (w_fmt)
      FMT_I:   o_word = {i_imm[11:0], i_rs1, w_f3, i_rd, OPC_OP_IMM};
      FMT_SH:  o_word = {w_f7, i_imm[4:0], i_rs1, w_f3, i_rd, OPC_OP_IMM};
      FMT_R:   o_word = {w_f7, i_rs2, i_rs1, w_f3, i_rd, OPC_OP};
      FMT_B:   o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, w_f3, i_imm[4:1], i_imm[11], OPC_BRANCH};
      FMT_U:   o_word = {i_imm[31:12], i_rd, OPC_LUI};
      FMT_J:   o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OPC_JAL};
      default: o_word = 32'h0;
    endcase
    o_bad = (w_fmt == FMT_NONE) || w_range_bad;
  end
`ifdef INS_ENC_RANGE_CHECK_EN
  // immediates that do not fit their field (or misaligned targets) are rejected
  always_comb begin
    case (w_fmt)
      FMT_I:   w_range_bad = !in_rng(i_imm, -32'sd2048, 32'sd2047);
      FMT_SH:  w_range_bad = !in_rng(i_imm, 32'sd0, 32'sd31);
      FMT_B:   w_range_bad = i_imm[0] || !in_rng(i_imm, -32'sd4096, 32'sd4094);
      FMT_J:   w_range_bad = i_imm[0] || !in_rng(i_imm, -32'sd1048576, 32'sd1048574);
      FMT_U:   w_range_bad = |i_imm[11:0];
      default: w_range_bad = 1'b0;
    endcase
  end
`else
  assign w_range_bad = 1'b0;
`endif
endmodule

// File: rtl/ins_encoder.sv
// ins_encoder: packs decoded fields into RV32I words and writes them sequentially to instruction ROM (option: INS_ENC_RANGE_CHECK_EN)
module ins_encoder
  import ins_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          DEPTH     = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  oh,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic        rom_wen,
  output logic [31:0] rom_waddr,
  output logic [31:0] rom_wdata,
  output logic        err,
  output logic [31:0] count,
  output logic        full
);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  state_t      r_state;
  state_t      w_next;
  logic [6:0]  r_oh;
  logic [4:0]  r_rd;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [31:0] r_imm;
  logic [31:0] r_wdata;
  logic [31:0] r_count;
  logic [31:0] w_count_next;
  logic        r_err;
  logic        r_ready;
  logic        w_accept;
  logic [31:0] w_word;
  logic        w_bad;
  ins_pack u_pack (
    .i_oh   (r_oh),
    .i_rd   (r_rd),
    .i_rs1  (r_rs1),
    .i_rs2  (r_rs2),
    .i_imm  (r_imm),
    .o_word (w_word),
    .o_bad  (w_bad)
  );
  // next state and next count; clear wins over everything
  always_comb begin
    w_accept     = (r_state == S_IDLE) && r_ready && in_valid;
    w_next       = (r_state == S_IDLE) ? (w_accept ? S_ENC : S_IDLE) :
                   (r_state == S_ENC)  ? (w_bad ? S_IDLE : S_WR) : S_IDLE;
    w_next       = clear ? S_IDLE : w_next;
    w_count_next = clear ? 32'h0 :
                   (r_state == S_WR && r_count != DEPTH_W) ? r_count + 32'd1 : r_count;
  end
  // state, counter, captured request and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_count <= 32'h0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_wdata <= 32'h0;
      r_oh    <= 7'h0;
      r_rd    <= 5'h0;
      r_rs1   <= 5'h0;
      r_rs2   <= 5'h0;
      r_imm   <= 32'h0;
    end else begin
      r_state <= w_next;
      r_count <= w_count_next;
      r_ready <= (w_next == S_IDLE) && (w_count_next != DEPTH_W);
      r_err   <= !clear && (r_state == S_ENC) && w_bad;
      if (w_accept) begin
        r_oh  <= oh;
        r_rd  <= rd;
        r_rs1 <= rs1;
        r_rs2 <= rs2;
        r_imm <= imm;
      end
      if (!clear && r_state == S_ENC && !w_bad) r_wdata <= w_word;
    end
  end
  // the strobe is gated so a clear or reset arriving in WR suppresses the write at that edge
  assign rom_wen   = (r_state == S_WR) && rst_n && !clear;
  assign rom_waddr = BASE_ADDR + (r_count << 2);
  assign rom_wdata = r_wdata;
  assign err       = r_err;
  assign count     = r_count;
  assign full      = (r_count == DEPTH_W);
  assign in_ready  = r_ready;
endmodule

// File: doc/ins_encoder.md
# ins_encoder

Instruction encoder that packs decoded fields into 32-bit RV32I machine words and writes them sequentially into instruction memory. It uses the same op-code numbering (`oh`) and field set (rd, rs1, rs2, immediate) that the decode stage emits, so it is the encoding counterpart of the decoder. It sits between a test/boot controller and the instruction ROM write port, for self-loading programs and for round-trip checks against the decoder.

## Interface
- `BASE_ADDR`, default 32'h0: byte address of the first word written.
- `DEPTH`, default 256: maximum number of words written before `full` asserts.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `clear` input 1: synchronous; zeroes the word count and returns to IDLE.
- `in_valid` input 1: request valid.
- `in_ready` output 1: high only in IDLE while `!full`. Reset value 0.
- `oh` input 7: operation code. Supported values: 1 LUI, 3 JAL, 5 BEQ, 6 BNE, 7 BLT, 19 ADDI, 20 SLTI, 21 SLTIU, 25 SLLI, 26 SRLI, 27 SRAI, 28 ADD, 29 SUB.
- `rd`, `rs1`, `rs2` input 5 each: register indices.
- `imm` input 32: signed byte value. For LUI it is the full upper value; for shifts it is the shift amount.
- `rom_wen` output 1: one-cycle write strobe. Reset value 0.
- `rom_waddr` output 32: `BASE_ADDR + 4*count`. Reset value `BASE_ADDR`.
- `rom_wdata` output 32: encoded word. Reset value 0.
- `err` output 1: one-cycle pulse for a rejected request. Reset value 0.
- `count` output 32: number of words written. Reset value 0.
- `full` output 1: `count == DEPTH`. Reset value 0.

## Operation
- FSM states: IDLE, ENC, WR.
  - IDLE → ENC when `in_valid && in_ready`. The inputs are captured into registers.
  - ENC → WR if the request is valid.
  - ENC → IDLE if `oh` is unsupported or a range check fails. `err` pulses and no write occurs.
  - WR → IDLE always. `rom_wen=1` and `count` increments.
- Encoding formats:
  - I-type: `{imm[11:0], rs1, f3, rd, 7'h13}`.
  - Shifts: `{f7, imm[4:0], rs1, f3, rd, 7'h13}`, with f7 = 0x20 for SRAI and 0x00 otherwise.
  - R-type: `{f7, rs2, rs1, f3, rd, 7'h33}`.
  - B-type: `{imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63}`.
  - U-type: `{imm[31:12], rd, 7'h37}`.
  - J-type: `{imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F}`.
- f3 values: ADDI/ADD/SUB/BEQ 0, SLLI/BNE 1, SLTI 2, SLTIU 3, BLT 4, SRLI/SRAI 5.
- Fields a format does not use are ignored: rs2 for I/U/J, rd for B, rs1 for U/J.
- `full`: `in_ready=0` and `in_valid` is ignored. Only `clear` or reset resumes operation.
- `clear` overrides every state, including WR. If asserted in WR, no write is issued and `count=0`.
- `count` saturates at DEPTH. No wrap-around.

## Timing
- Handshake accepted on edge N.
- Edge N+1: ENC, `rom_wdata` registered.
- Edge N+2: WR, so `rom_wen`, `rom_waddr` and `rom_wdata` are valid during cycle N+2.
- Edge N+3: IDLE, `count` updated; `in_ready` high again if not full.
- Throughput: one word per 3 cycles.
- `err` is high during the cycle after ENC, i.e. in the cycle where the state is IDLE following a reject.
- `rom_waddr` is stable from ENC through WR and reflects the pre-increment count.
- Reset asserted mid-operation: the next edge forces all outputs to their reset values. A pending WR is dropped.

## Configuration
- `INS_ENC_RANGE_CHECK_EN` defined:
  - reject I-type imm outside −2048..2047;
  - reject shift imm outside 0..31;
  - reject B imm that is odd or outside −4096..4094;
  - reject J imm that is odd or outside ±1 MiB (−1048576..1048574);
  - reject U imm with a nonzero `imm[11:0]`.
- Not defined: immediates are truncated silently to their field bits. Only an unsupported `oh` raises `err`.

## Structure
- Shared package `ins_pkg` holds:
  - opcode constants 0x13, 0x33, 0x63, 0x37, 0x6F;
  - f3/f7 constants;
  - `oh` code constants, shared with the decoder.
- Sub-module `ins_pack`: purely combinational field packer plus range check (`oh`, fields, imm → word, bad). The top holds the FSM, registers and counter.

## Test plan
- ADDI rd=1 rs1=0 imm=5 → `rom_wdata=0x00500093` at `BASE_ADDR`, `rom_wen` high in cycle N+2, `count=1`.
- SUB rd=3 rs1=1 rs2=2 → `0x402081B3`; BEQ rs1=1 rs2=2 imm=−8 → `0xFE208CE3`.
- LUI rd=5 imm=0x12345000 → `0x123452B7`; JAL rd=1 imm=8 → `0x008000EF`.
- ADDI imm=4096 with the macro defined → `err` pulse, no `rom_wen`, count unchanged. Without the macro → word `0x00000093`.
- `DEPTH=4`, four requests → `full=1`, `in_ready=0`, fifth request ignored. `clear` → `count=0`, next write lands at `BASE_ADDR`.
- Reset, or `clear`, asserted during WR → no write, outputs at reset values / `count=0`. Unsupported `oh=2` → `err` pulse only.
